// File: rtl/crc_pkg.sv
// Shared widths and the ceil-log2 helper for the CRC result merger.
// Pure declarations: no latency, no backpressure.
package crc_pkg;
  localparam int CRC_W = 32;
  localparam int SEQ_W = 16;

  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/crc_result_merger_if.sv
// Lane strobes/CRCs in, one valid-ready result stream plus status out.
// slave is the merger side, master is the producer/consumer side.
interface crc_result_merger_if #(
  parameter int PKT_NUM    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LANE_W     = 3
);
  import crc_pkg::*;
  localparam int LVL_W = clogb2(FIFO_DEPTH) + 1;

  logic [PKT_NUM-1:0]       crc_en_in;
  logic [CRC_W*PKT_NUM-1:0] crc_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [CRC_W-1:0]         out_crc;
  logic [LANE_W-1:0]        out_lane;
  logic [SEQ_W-1:0]         out_seq;
  logic [LVL_W-1:0]         fifo_level;
  logic                     overflow;
  logic [15:0]              drop_cnt;

  modport slave (
    input  crc_en_in, crc_in, out_ready,
    output out_valid, out_crc, out_lane, out_seq, fifo_level, overflow, drop_cnt
  );

  modport master (
    output crc_en_in, crc_in, out_ready,
    input  out_valid, out_crc, out_lane, out_seq, fifo_level, overflow, drop_cnt
  );
endinterface

// File: rtl/lane_prefix_count.sv
// Exclusive prefix popcount per lane plus total batch size; purely combinational.
// No backpressure: result follows the strobe vector in the same cycle.
module lane_prefix_count #(
  parameter int PKT_NUM = 8,
  parameter int LANE_W  = 3
) (
  input  logic [PKT_NUM-1:0]             en,
  output logic [PKT_NUM-1:0][LANE_W-1:0] prefix,
  output logic [LANE_W:0]                cnt
);
  always_comb begin
    logic [LANE_W:0] acc;
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < PKT_NUM; i++) begin
      prefix[i] = acc[LANE_W-1:0];
      acc       = acc + (LANE_W+1)'(en[i]);
    end
    cnt = acc;
  end
endmodule

// File: rtl/crc_result_merger.sv
// Packs per-lane CRC strobes into one FIFO, lane-ascending, all-or-nothing per batch.
// Head visible 1 cycle after write; out_ready low holds the head, full batches are dropped and counted.
module crc_result_merger #(
  parameter int PKT_NUM    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LANE_W     = 3
) (
  input logic               clk,
  input logic               rst,
  crc_result_merger_if.slave bus
);
  import crc_pkg::*;

  localparam int AW = clogb2(FIFO_DEPTH);
  localparam int EW = LANE_W + CRC_W;

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [SEQ_W-1:0]   seq;
  logic               overflow_q;
  logic [15:0]        drop_q;
  logic [EW-1:0]      mem [FIFO_DEPTH];

  logic [PKT_NUM-1:0][LANE_W-1:0] prefix;
  logic [LANE_W:0]    batch_cnt;
  logic [AW:0]        level;
  logic               pop;
  logic [AW+1:0]      free;
  logic               accept;
  logic [16:0]        drop_sum;
  logic [EW-1:0]      head;

  lane_prefix_count #(
    .PKT_NUM (PKT_NUM),
    .LANE_W  (LANE_W)
  ) u_prefix (
    .en     (bus.crc_en_in),
    .prefix (prefix),
    .cnt    (batch_cnt)
  );

  assign level    = wr_ptr - rd_ptr;
  assign pop      = (level != '0) && bus.out_ready;
  // A same-cycle pop lends its slot to the incoming batch.
  assign free     = (AW+2)'(FIFO_DEPTH) - {1'b0, level} + (AW+2)'(pop);
  assign accept   = int'(batch_cnt) <= int'(free);
  assign drop_sum = {1'b0, drop_q} + 17'(batch_cnt);
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < PKT_NUM; i++) begin
        if (bus.crc_en_in[i])
          mem[wr_ptr[AW-1:0] + AW'(prefix[i])] <= {LANE_W'(i), bus.crc_in[CRC_W*i +: CRC_W]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq        <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + (AW+1)'(batch_cnt);
      end else begin
        overflow_q <= 1'b1;
        drop_q     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        seq    <= seq + 1'b1;
      end
    end
  end

  // Storage is not reset, so gate the head fields with valid.
  assign bus.out_valid  = (level != '0);
  assign bus.out_crc    = bus.out_valid ? head[CRC_W-1:0] : '0;
  assign bus.out_lane   = bus.out_valid ? head[EW-1:CRC_W] : '0;
  assign bus.out_seq    = seq;
  assign bus.fifo_level = level;
  assign bus.overflow   = overflow_q;
  assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_crc_result_merger.sv
// Directed bench for crc_result_merger: vector table plus hand-written overflow,
// stall, sequence-wrap and reset sequences, checked against a queue of expected entries.
module tb_crc_result_merger;
  logic clk;
  logic rst;

  crc_result_merger_if #(.PKT_NUM(8), .FIFO_DEPTH(16), .LANE_W(3)) bus ();

  crc_result_merger #(.PKT_NUM(8), .FIFO_DEPTH(16), .LANE_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  en;
    logic [31:0] base;
    logic [31:0] exp_level;
    logic        exp_valid;
    logic [31:0] exp_lane;
    logic [31:0] exp_crc;
  } vec_t;

  typedef struct packed {
    logic [2:0]  lane;
    logic [31:0] crc;
  } ent_t;

  vec_t        vecs[6];
  ent_t        q[$];
  int          n_checks;
  int          n_fail;
  logic [15:0] exp_seq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] en, input logic [31:0] base);
    bus.crc_en_in = en;
    for (int i = 0; i < 8; i++) bus.crc_in[32*i +: 32] = base + 32'(i);
  endtask

  task automatic push_exp(input logic [7:0] en, input logic [31:0] base);
    ent_t e;
    for (int i = 0; i < 8; i++) begin
      if (en[i]) begin
        e.lane = 3'(i);
        e.crc  = base + 32'(i);
        q.push_back(e);
      end
    end
  endtask

  // Checks the current head against the model; the caller's next tick pops it.
  task automatic pop_chk(input string nm);
    ent_t e;
    if (q.size() == 0) begin
      chk({nm, "_model_empty"}, 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_lane"}, 32'(bus.out_lane), 32'(e.lane));
    chk({nm, "_crc"}, bus.out_crc, e.crc);
    chk({nm, "_seq"}, 32'(bus.out_seq), 32'(exp_seq));
    exp_seq++;
  endtask

  task automatic drain(input string nm, input int n);
    bus.out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      pop_chk(nm);
      tick();
    end
    bus.out_ready = 1'b0;
    chk({nm, "_empty"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic        saw_wrap;
    logic [15:0] prev_seq;
    ent_t        h;

    n_checks = 0;
    n_fail   = 0;
    exp_seq  = '0;
    rst           = 1'b1;
    bus.crc_en_in = '0;
    bus.crc_in    = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{8'h01, 32'h1000_0000, 32'd1, 1'b1, 32'd0, 32'h1000_0000};
    vecs[1] = '{8'h80, 32'h2000_0000, 32'd1, 1'b1, 32'd7, 32'h2000_0007};
    vecs[2] = '{8'h24, 32'h3000_0000, 32'd2, 1'b1, 32'd2, 32'h3000_0002};
    vecs[3] = '{8'hF0, 32'h4000_0000, 32'd4, 1'b1, 32'd4, 32'h4000_0004};
    vecs[4] = '{8'hFF, 32'h5000_0000, 32'd8, 1'b1, 32'd0, 32'h5000_0000};
    vecs[5] = '{8'h00, 32'h6000_0000, 32'd0, 1'b0, 32'd0, 32'h0};

    repeat (2) tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
    chk("rst_seq", 32'(bus.out_seq), 32'd0);
    chk("rst_crc", bus.out_crc, 32'd0);
    rst = 1'b0;
    tick();

    // Two lanes in one batch, consumer always ready.
    bus.crc_in = '0;
    bus.crc_in[31:0]  = 32'hDEADBEEF;
    bus.crc_in[95:64] = 32'h12345678;
    bus.crc_en_in = 8'b0000_0101;
    bus.out_ready = 1'b1;
    tick();
    bus.crc_en_in = '0;
    chk("pair0_valid", 32'(bus.out_valid), 32'd1);
    chk("pair0_lane", 32'(bus.out_lane), 32'd0);
    chk("pair0_crc", bus.out_crc, 32'hDEADBEEF);
    chk("pair0_seq", 32'(bus.out_seq), 32'd0);
    tick();
    chk("pair1_valid", 32'(bus.out_valid), 32'd1);
    chk("pair1_lane", 32'(bus.out_lane), 32'd2);
    chk("pair1_crc", bus.out_crc, 32'h12345678);
    chk("pair1_seq", 32'(bus.out_seq), 32'd1);
    tick();
    chk("pair_empty", 32'(bus.out_valid), 32'd0);
    exp_seq = 16'd2;
    bus.out_ready = 1'b0;

    for (int v = 0; v < 6; v++) begin
      drive(vecs[v].en, vecs[v].base);
      tick();
      bus.crc_en_in = '0;
      chk("vec_level", 32'(bus.fifo_level), vecs[v].exp_level);
      chk("vec_valid", 32'(bus.out_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) begin
        chk("vec_head_lane", 32'(bus.out_lane), vecs[v].exp_lane);
        chk("vec_head_crc", bus.out_crc, vecs[v].exp_crc);
      end
      push_exp(vecs[v].en, vecs[v].base);
      drain("vec_drain", int'(vecs[v].exp_level));
      chk("vec_overflow", 32'(bus.overflow), 32'd0);
    end

    // Fill to 16 with the consumer stalled, then overrun by a batch of 3.
    drive(8'hFF, 32'hA000_0000);
    tick();
    drive(8'hFF, 32'hB000_0000);
    tick();
    bus.crc_en_in = '0;
    push_exp(8'hFF, 32'hA000_0000);
    push_exp(8'hFF, 32'hB000_0000);
    chk("full_level", 32'(bus.fifo_level), 32'd16);
    chk("full_overflow", 32'(bus.overflow), 32'd0);
    drive(8'h07, 32'hC000_0000);
    tick();
    bus.crc_en_in = '0;
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_drop", 32'(bus.drop_cnt), 32'd3);
    chk("ovf_level", 32'(bus.fifo_level), 32'd16);

    // Full FIFO: pop and single-lane push in the same cycle.
    drive(8'h08, 32'hD000_0000);
    bus.out_ready = 1'b1;
    pop_chk("fullpp");
    tick();
    bus.crc_en_in = '0;
    bus.out_ready = 1'b0;
    push_exp(8'h08, 32'hD000_0000);
    chk("fullpp_level", 32'(bus.fifo_level), 32'd16);
    chk("fullpp_drop", 32'(bus.drop_cnt), 32'd3);
    chk("fullpp_overflow", 32'(bus.overflow), 32'd1);

    // Five-cycle stall: head must not move.
    h = q[0];
    for (int s = 0; s < 5; s++) begin
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_lane", 32'(bus.out_lane), 32'(h.lane));
      chk("stall_crc", bus.out_crc, h.crc);
      chk("stall_seq", 32'(bus.out_seq), 32'(exp_seq));
      tick();
    end
    drain("release", 16);
    chk("release_level", 32'(bus.fifo_level), 32'd0);

    // Stream single-lane results through the 16-bit sequence wrap.
    saw_wrap = 1'b0;
    prev_seq = bus.out_seq;
    bus.out_ready = 1'b1;
    for (int j = 0; j <= 65540; j++) begin
      if (j < 65540) begin
        bus.crc_en_in = 8'h01;
        bus.crc_in[31:0] = 32'(j);
      end else begin
        bus.crc_en_in = '0;
      end
      if (j > 0) begin
        chk("wrap_valid", 32'(bus.out_valid), 32'd1);
        chk("wrap_crc", bus.out_crc, 32'(j - 1));
        chk("wrap_seq", 32'(bus.out_seq), 32'(exp_seq));
        if (prev_seq == 16'hFFFF && bus.out_seq == 16'h0000) saw_wrap = 1'b1;
        prev_seq = bus.out_seq;
        exp_seq++;
      end
      tick();
    end
    bus.out_ready = 1'b0;
    chk("wrap_seen", 32'(saw_wrap), 32'd1);
    chk("wrap_level", 32'(bus.fifo_level), 32'd0);
    chk("wrap_drop", 32'(bus.drop_cnt), 32'd3);

    // Reset mid-operation with 6 entries buffered.
    drive(8'h3F, 32'hE000_0000);
    tick();
    bus.crc_en_in = '0;
    chk("prerst_level", 32'(bus.fifo_level), 32'd6);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_level", 32'(bus.fifo_level), 32'd0);
    chk("midrst_overflow", 32'(bus.overflow), 32'd0);
    chk("midrst_drop", 32'(bus.drop_cnt), 32'd0);
    rst = 1'b0;
    q.delete();
    exp_seq = '0;
    tick();
    drive(8'h02, 32'hF000_0000);
    tick();
    bus.crc_en_in = '0;
    chk("postrst_valid", 32'(bus.out_valid), 32'd1);
    chk("postrst_lane", 32'(bus.out_lane), 32'd1);
    chk("postrst_crc", bus.out_crc, 32'hF000_0001);
    chk("postrst_seq", 32'(bus.out_seq), 32'd0);
    chk("postrst_level", 32'(bus.fifo_level), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/crc_result_merger.md
CRC_RESULT_MERGER -- requirements
Module: crc_result_merger

Interface
REQ-001 SHALL have parameter PKT_NUM, default 8; number of parallel CRC result lanes.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16; result FIFO entries; power of two; at least PKT_NUM.
REQ-003 SHALL have parameter LANE_W, default 3; lane index width, equal to clogb2(PKT_NUM).
REQ-004 SHALL have port clk, input, 1; single clock for all logic.
REQ-005 SHALL have port rst, input, 1; reset, asynchronous and active-high.
REQ-006 SHALL have port crc_en_in, input, PKT_NUM; per-lane one-cycle strobe marking a valid final CRC.
REQ-007 SHALL have port crc_in, input, 32*PKT_NUM; lane i CRC on bits [32*(i+1)-1 -: 32].
REQ-008 SHALL have port out_valid, output, 1; out_crc, out_lane and out_seq are valid.
REQ-009 SHALL have port out_ready, input, 1; consumer accepts the entry when out_valid and out_ready are both high.
REQ-010 SHALL have port out_crc, output, 32; CRC value of the head entry.
REQ-011 SHALL have port out_lane, output, LANE_W; source lane of the head entry.
REQ-012 SHALL have port out_seq, output, 16; running sequence number of the head entry.
REQ-013 SHALL have port fifo_level, output, clogb2(FIFO_DEPTH)+1; current occupancy.
REQ-014 SHALL have port overflow, output, 1; sticky drop flag.
REQ-015 SHALL have port drop_cnt, output, 16; count of dropped CRC results, saturating at 0xFFFF.

Function
REQ-016 SHALL treat each cycle's set of asserted crc_en_in bits as one batch of size P, the popcount of crc_en_in.
REQ-017 SHALL write an accepted batch in one cycle, in ascending lane order, at wr_ptr+k, where k is the number of set bits below that lane.
REQ-018 SHALL accept a batch only if P is at most the free space, with free space evaluated after any same-cycle pop.
REQ-019 SHALL drop the whole batch when P exceeds the free space: no partial write; set overflow; add P to drop_cnt, saturating.
REQ-020 SHALL advance wr_ptr by P and rd_ptr by 1 per pop; both pointers wrap modulo FIFO_DEPTH, and one extra bit distinguishes full from empty.
REQ-021 SHALL give a 1-cycle latency: an entry written at edge N shall make out_valid high after edge N when the FIFO was empty.
REQ-022 SHALL hold out_valid, out_crc, out_lane and out_seq stable while out_valid is high and out_ready is low.
REQ-023 SHALL pop exactly one entry per cycle when out_valid and out_ready are both high; the next entry shall appear the following cycle with no bubble.
REQ-024 SHALL assign out_seq from a 16-bit counter that increments per pop and wraps 0xFFFF to 0x0000.
REQ-025 SHALL allow a simultaneous push and pop on a full FIFO; the pop frees one slot for that cycle's batch.
REQ-026 SHALL treat P=0 as no write, with no effect on overflow or drop_cnt.
REQ-027 SHALL update fifo_level each cycle as previous level + accepted P - pop.
REQ-028 SHALL ignore crc_in bits whose lane strobe is low.

Reset
REQ-029 SHALL, on rst high, asynchronously clear pointers, out_valid, out_crc, out_lane, out_seq counter, fifo_level, overflow and drop_cnt to 0.
REQ-030 SHALL discard all buffered results when rst is asserted mid-operation; the first result after reset release shall carry out_seq 0.
REQ-031 SHALL provide that overflow clears only on rst.

Structure
REQ-032 SHALL place CRC_W=32, SEQ_W=16 and the clogb2 function in shared package crc_pkg.
REQ-033 SHALL implement the per-lane exclusive prefix count and batch popcount in sub-module lane_prefix_count.
REQ-034 SHALL implement storage as a register array of {lane, crc}; no vendor primitives.

Verification
REQ-035 SHALL cover: crc_en_in=8'b0000_0101 with lane0=0xDEADBEEF and lane2=0x12345678, out_ready=1 -> outputs (lane0, 0xDEADBEEF, seq0) then (lane2, 0x12345678, seq1) on consecutive cycles.
REQ-036 SHALL cover: out_ready=0 with two all-lanes batches (FIFO 16/16), then a third batch of 3 -> batch dropped, overflow=1, drop_cnt=3, fifo_level=16.
REQ-037 SHALL cover: full FIFO with out_ready=1 and a batch of 1 in the same cycle -> accepted, fifo_level stays 16, no drop.
REQ-038 SHALL cover: stall of 5 cycles with out_valid high -> outputs unchanged throughout; release -> one pop per cycle.
REQ-039 SHALL cover: 65540 single-lane results -> out_seq wraps to 0 after 0xFFFF, with no lost entries.
REQ-040 SHALL cover: rst pulse with 6 entries buffered -> out_valid=0 and fifo_level=0 immediately; next result carries out_seq 0.
